// File: rtl/program_loader.sv
// program_loader: writable 4-bit program store for the CPU.
// Clears itself to NOP_OPCODE after reset. It then accepts a program through a
// loadValid/loadReady stream and pads the unwritten tail with NOP_OPCODE.
// The CPU fetch port (addressIn -> dataOut) is combinational.
// Optional feature macro: LOADER_CHECKSUM_EN adds the loadChecksum output
// (running XOR of the beats accepted in the current load).
//
// Handshake: a beat transfers on a rising edge where loadValid && loadReady.
// loadReady is high only in LOAD and only when loadStart is low. A loadStart
// in LOAD restarts the load and takes priority, so a beat offered in that same
// cycle is never acknowledged and is dropped.
module program_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [3:0]  NOP_OPCODE = 4'b0111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadStart,
    input  logic                  loadValid,
    input  logic [3:0]            loadData,
    input  logic                  loadLast,
    output logic                  loadReady,
    input  logic [ADDR_WIDTH-1:0] addressIn,
    output logic [3:0]            dataOut,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic [ADDR_WIDTH:0]   programLength,
    output logic                  overflowErr
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [3:0]            loadChecksum
`endif
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH+1)'(DEPTH);

    // The state register is a plain internal signal so checkers can bind to it.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] writePtr;
    logic [3:0]            mem [DEPTH];

    logic                  ptr_at_end;
    logic                  accept;
    logic                  wr_en;
    logic [3:0]            wr_data;
    logic                  done_nxt;
    logic                  start_load;

    assign ptr_at_end = (writePtr == LAST_ADDR);
    // loadStart only counts in IDLE and LOAD; CLEAR and FILL ignore it.
    assign start_load = loadStart && ((state == ST_IDLE) || (state == ST_LOAD));

    // Next-state, write-port control and handshake/hold outputs.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_data   = NOP_OPCODE;
        cpuHold   = 1'b1;
        loadReady = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_CLEAR: begin
                wr_en = 1'b1;
                if (ptr_at_end) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                cpuHold = 1'b0;
                if (loadStart) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                loadReady = !loadStart;
                accept    = loadValid && !loadStart;
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_data = loadData;
                    if (loadLast && !ptr_at_end) begin
                        state_nxt = ST_FILL;
                    end else if (ptr_at_end) begin
                        // Either the last beat landed on the final address or
                        // the memory filled up without one; both finish here.
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                wr_en = 1'b1;
                if (ptr_at_end) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // State, pointer, length and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_CLEAR;
            writePtr      <= '0;
            loadDone      <= 1'b0;
            programLength <= '0;
            overflowErr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            loadDone <= done_nxt;
            if (start_load) begin
                writePtr      <= '0;
                programLength <= '0;
                overflowErr   <= 1'b0;
            end else begin
                // The pointer wraps to 0 after the last address, ready for IDLE.
                if (wr_en) writePtr <= writePtr + 1'b1;
                if (accept && (programLength != MAX_LEN))
                    programLength <= programLength + 1'b1;
                if (accept && !loadLast && ptr_at_end)
                    overflowErr <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of accepted beats; fill writes never contribute.
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            loadChecksum <= 4'b0000;
        end else if (accept) begin
            loadChecksum <= loadChecksum ^ loadData;
        end
    end
`endif

    // Single write port into the program store.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[writePtr] <= wr_data;
        end
    end

    // The CPU sees NOP whenever it is held, so stale or unknown data never leaks.
    assign dataOut = cpuHold ? NOP_OPCODE : mem[addressIn];

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized bench for program_loader
// with ADDR_WIDTH = 4 (16 x 4-bit store).
module tb_program_loader;

    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [3:0] NOP   = 4'b0111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          loadStart = 1'b0;
    logic          loadValid = 1'b0;
    logic [3:0]    loadData = 4'b0000;
    logic          loadLast = 1'b0;
    logic          loadReady;
    logic [AW-1:0] addressIn = '0;
    logic [3:0]    dataOut;
    logic          cpuHold;
    logic          loadDone;
    logic [AW:0]   programLength;
    logic          overflowErr;
`ifdef LOADER_CHECKSUM_EN
    logic [3:0]    loadChecksum;
`endif

    int checks = 0;
    int errors = 0;

    program_loader #(.ADDR_WIDTH(AW), .NOP_OPCODE(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .loadStart     (loadStart),
        .loadValid     (loadValid),
        .loadData      (loadData),
        .loadLast      (loadLast),
        .loadReady     (loadReady),
        .addressIn     (addressIn),
        .dataOut       (dataOut),
        .cpuHold       (cpuHold),
        .loadDone      (loadDone),
        .programLength (programLength),
        .overflowErr   (overflowErr)
`ifdef LOADER_CHECKSUM_EN
        ,
        .loadChecksum  (loadChecksum)
`endif
    );

    // Clock: 10 time-unit period; inputs change on the falling edge.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected store image after a completed load: beats, then NOP padding.
    function automatic logic [3:0] model_word(input logic [63:0] beats, input int n, input int addr);
        logic [63:0] b;
        b = beats;
        return (addr < n) ? b[addr*4 +: 4] : NOP;
    endfunction

    function automatic logic [3:0] model_xor(input logic [63:0] beats, input int n);
        logic [3:0]  x;
        logic [63:0] b;
        x = 4'b0000;
        b = beats;
        for (int i = 0; i < n; i++) x = x ^ b[i*4 +: 4];
        return x;
    endfunction

    // Sweep the whole read port in IDLE against an expected image.
    task automatic sweep(input string name, input logic [63:0] beats, input int n);
        for (int a = 0; a < DEPTH; a++) begin
            addressIn = AW'(a);
            #1;
            check(name, {28'd0, dataOut}, {28'd0, model_word(beats, n, a)});
        end
    endtask

    // Reset for one cycle, then expect a 16-cycle CLEAR with the CPU held,
    // NOP on the read port, no loadDone and a loadStart pulse ignored.
    task automatic reset_and_check(input string name);
        int cnt;
        bit bad;
        @(negedge clk);
        reset     = 1'b1;
        loadStart = 1'b0;
        loadValid = 1'b0;
        loadLast  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({name, "_hold"},   {31'd0, cpuHold}, 32'd1);
        check({name, "_ready"},  {31'd0, loadReady}, 32'd0);
        check({name, "_done"},   {31'd0, loadDone}, 32'd0);
        check({name, "_len"},    {27'd0, programLength}, 32'd0);
        check({name, "_ovf"},    {31'd0, overflowErr}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check({name, "_csum"},   {28'd0, loadChecksum}, 32'd0);
`endif
        cnt = 0;
        bad = 1'b0;
        while (cpuHold === 1'b1 && cnt < 100) begin
            if (loadDone !== 1'b0 || dataOut !== NOP) bad = 1'b1;
            cnt++;
            loadStart = (cnt == 5);
            addressIn = AW'($urandom_range(0, DEPTH-1));
            @(negedge clk);
            #1;
        end
        loadStart = 1'b0;
        check({name, "_clear_cycles"}, cnt, 32'd16);
        check({name, "_clear_quiet"},  {31'd0, bad}, 32'd0);
        check({name, "_idle_ready"},   {31'd0, loadReady}, 32'd0);
        sweep({name, "_mem"}, 64'd0, 0);
    endtask

    // Drive one load (optionally preceded by its loadStart pulse) and check
    // handshake, fill length, done pulse, status outputs and store contents.
    task automatic run_load(input string name, input bit send_start, input logic [63:0] beats,
                            input int n, input int gap_mode, input bit with_last,
                            input int exp_len, input bit exp_ovf, input int exp_fill,
                            input logic [3:0] exp_csum);
        int sent, cyc, ready_cycles, k, phase;
        bit v;
        logic [63:0] b;
        b = beats;
        if (send_start) begin
            @(negedge clk);
            loadStart = 1'b1;
            loadValid = 1'b0;
            @(negedge clk);
            loadStart = 1'b0;
            #1;
            check({name, "_start_hold"}, {31'd0, cpuHold}, 32'd1);
            check({name, "_start_len"},  {27'd0, programLength}, 32'd0);
            check({name, "_start_ovf"},  {31'd0, overflowErr}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
            check({name, "_start_csum"}, {28'd0, loadChecksum}, 32'd0);
`endif
        end
        sent = 0;
        cyc = 0;
        ready_cycles = 0;
        phase = 0;
        while (sent < n && cyc < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (phase % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            phase++;
            loadValid = v;
            loadData  = b[sent*4 +: 4];
            loadLast  = with_last && (sent == n - 1);
            #1;
            if (loadReady === 1'b1) ready_cycles++;
            if (v && loadReady === 1'b1) sent++;
            cyc++;
            @(negedge clk);
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        check({name, "_beats_sent"},   sent, n);
        check({name, "_ready_cycles"}, ready_cycles, cyc);
        k = 0;
        #1;
        while (loadDone !== 1'b1 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, "_fill_cycles"}, k, exp_fill);
        check({name, "_done_hold"},   {31'd0, cpuHold}, 32'd0);
        check({name, "_len"},         {27'd0, programLength}, exp_len);
        check({name, "_ovf"},         {31'd0, overflowErr}, {31'd0, exp_ovf});
`ifdef LOADER_CHECKSUM_EN
        check({name, "_csum"},        {28'd0, loadChecksum}, {28'd0, exp_csum});
`else
        check({name, "_csum_model"},  {28'd0, model_xor(beats, n)}, {28'd0, exp_csum});
`endif
        @(negedge clk);
        #1;
        check({name, "_done_pulse"}, {31'd0, loadDone}, 32'd0);
        sweep({name, "_mem"}, beats, n);
    endtask

    typedef struct {
        string       name;
        logic [63:0] beats;
        int          n;
        int          gap_mode;
        bit          with_last;
        int          exp_len;
        bit          exp_ovf;
        int          exp_fill;
        logic [3:0]  exp_csum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          n;
        bit          wl;
        logic [63:0] rb;

        vecs[0] = '{"basic4",   64'h0000_0000_0000_2A10, 4,  0, 1'b1, 4,  1'b0, 12, 4'h9};
        vecs[1] = '{"toggle3",  64'h0000_0000_0000_09C5, 3,  1, 1'b1, 3,  1'b0, 13, 4'h0};
        vecs[2] = '{"overflow", 64'h8888_8888_8888_8888, 16, 0, 1'b0, 16, 1'b1, 0,  4'h0};
        vecs[3] = '{"csum3",    64'h0000_0000_0000_036A, 3,  0, 1'b1, 3,  1'b0, 13, 4'hF};
        vecs[4] = '{"single",   64'h0000_0000_0000_000F, 1,  0, 1'b1, 1,  1'b0, 15, 4'hF};

        repeat (2) @(negedge clk);
        reset_and_check("reset");

        for (int i = 0; i < 5; i++) begin
            run_load(vecs[i].name, 1'b1, vecs[i].beats, vecs[i].n, vecs[i].gap_mode,
                     vecs[i].with_last, vecs[i].exp_len, vecs[i].exp_ovf,
                     vecs[i].exp_fill, vecs[i].exp_csum);
        end

        // Restart mid-load: two beats in, then loadStart with a beat offered.
        @(negedge clk);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        loadValid = 1'b1;
        loadData  = 4'h3;
        @(negedge clk);
        loadData  = 4'h4;
        @(negedge clk);
        loadStart = 1'b1;
        loadData  = 4'hF;
        @(negedge clk);
        loadStart = 1'b0;
        loadValid = 1'b0;
        #1;
        check("restart_len", {27'd0, programLength}, 32'd0);
        @(negedge clk);
        run_load("restart", 1'b0, 64'h0000_0000_0000_0DB1, 3, 0, 1'b1, 3, 1'b0, 13, 4'h7);

        // Reset after 2 of 5 beats: everything returns to NOP.
        @(negedge clk);
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        loadValid = 1'b1;
        loadData  = 4'h5;
        @(negedge clk);
        loadData  = 4'h6;
        @(negedge clk);
        loadValid = 1'b0;
        reset_and_check("midreset");

        // Randomized loads against the store-image model.
        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(1, DEPTH);
            wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            rb = {$urandom, $urandom};
            run_load("rand", 1'b1, rb, n, 2, wl, n, !wl, DEPTH - n, model_xor(rb, n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
